// File: rtl/traffic_monitor.sv
// traffic_monitor: passive checker beside the traffic light controller.
// Tracks the lamp phase sequence, times each phase, cross-checks the
// reported phase count and counts completed light cycles. Status only.
module traffic_monitor #(
  parameter int unsigned GREEN_LEN  = 11,
  parameter int unsigned YELLOW_LEN = 6,
  parameter int unsigned RED_LEN    = 16,
  parameter bit          CHK_COUNT  = 1'b1
) (
  input  logic       in_clk,
  input  logic       in_rst,
  input  logic       in_green,
  input  logic       in_yellow,
  input  logic       in_red,
  input  logic [3:0] in_count,
  input  logic       in_clr,
  output logic [2:0] o_phase,
  output logic       o_err,
  output logic [2:0] o_err_code,
  output logic [7:0] o_cycles
);

  typedef enum logic [2:0] {
    PH_IDLE    = 3'd0,
    PH_GREEN   = 3'd1,
    PH_YELLOW1 = 3'd2,
    PH_RED     = 3'd3,
    PH_YELLOW2 = 3'd4,
    PH_FAULT   = 3'd7
  } phase_t;

  // Lamp vector encodings, {r,y,g}
  localparam logic [2:0] L_OFF = 3'b000;
  localparam logic [2:0] L_G   = 3'b001;
  localparam logic [2:0] L_Y   = 3'b010;
  localparam logic [2:0] L_R   = 3'b100;

  localparam logic [2:0] ERR_NONE  = 3'd0;
  localparam logic [2:0] ERR_MULTI = 3'd1;
  localparam logic [2:0] ERR_SEQ   = 3'd2;
  localparam logic [2:0] ERR_SHORT = 3'd3;
  localparam logic [2:0] ERR_LONG  = 3'd4;
  localparam logic [2:0] ERR_COUNT = 3'd5;

  phase_t     phase_r;
  phase_t     next_phase_s;
  logic [7:0] rc_r;
  logic       err_r;
  logic [2:0] err_code_r;
  logic [7:0] cycles_r;

  logic [2:0] lamps_s;
  logic [2:0] held_lamps_s;
  logic       multi_s;
  logic       timed_s;
  logic [8:0] len_s;
  logic [8:0] held_len_s;
  logic       changed_s;
  logic       legal_s;
  logic       seq_err_s;
  logic       wrap_s;
  logic       short_s;
  logic       long_s;
  logic       cnt_bad_s;
  logic [3:0] exp_cnt_s;
  logic [2:0] code_s;

  assign lamps_s    = {in_red, in_yellow, in_green};
  assign multi_s    = (in_green & in_yellow) | (in_green & in_red) | (in_yellow & in_red);
  // Held length is one more than the run counter; 9 bits so a saturated rc never aliases LEN
  assign held_len_s = {1'b0, rc_r} + 9'd1;

  // Per-phase attributes: which lamp belongs to it and how long it must be held
  always_comb begin
    held_lamps_s = L_OFF;
    timed_s      = 1'b0;
    len_s        = 9'd0;
    case (phase_r)
      PH_GREEN: begin
        held_lamps_s = L_G;
        timed_s      = 1'b1;
        len_s        = 9'(GREEN_LEN);
      end
      PH_YELLOW1, PH_YELLOW2: begin
        held_lamps_s = L_Y;
        timed_s      = 1'b1;
        len_s        = 9'(YELLOW_LEN);
      end
      PH_RED: begin
        held_lamps_s = L_R;
        timed_s      = 1'b1;
        len_s        = 9'(RED_LEN);
      end
      default: begin
        held_lamps_s = L_OFF;
        timed_s      = 1'b0;
        len_s        = 9'd0;
      end
    endcase
  end

  // Phase transition decode with sequence and duration checks
  always_comb begin
    next_phase_s = phase_r;
    changed_s    = 1'b0;
    legal_s      = 1'b0;
    seq_err_s    = 1'b0;
    wrap_s       = 1'b0;
    short_s      = 1'b0;
    long_s       = 1'b0;
    if (multi_s) begin
      next_phase_s = PH_FAULT;
      changed_s    = (phase_r != PH_FAULT);
    end else if (lamps_s == L_OFF) begin
      // Going dark is always allowed and skips the short check
      next_phase_s = PH_IDLE;
      changed_s    = (phase_r != PH_IDLE);
    end else if (phase_r == PH_FAULT) begin
      // Only a dark lamp set releases FAULT
      next_phase_s = PH_FAULT;
    end else if (lamps_s != held_lamps_s) begin
      changed_s = 1'b1;
      short_s   = timed_s && (held_len_s < len_s);
      case (phase_r)
        PH_IDLE:    legal_s = (lamps_s == L_G);
        PH_GREEN:   legal_s = (lamps_s == L_Y);
        PH_YELLOW1: legal_s = (lamps_s == L_R);
        PH_RED:     legal_s = (lamps_s == L_Y);
        PH_YELLOW2: legal_s = (lamps_s == L_G);
        default:    legal_s = 1'b0;
      endcase
      if (legal_s) begin
        case (phase_r)
          PH_IDLE:    next_phase_s = PH_GREEN;
          PH_GREEN:   next_phase_s = PH_YELLOW1;
          PH_YELLOW1: next_phase_s = PH_RED;
          PH_RED:     next_phase_s = PH_YELLOW2;
          PH_YELLOW2: begin
            next_phase_s = PH_GREEN;
            wrap_s       = 1'b1;
          end
          default:    next_phase_s = PH_FAULT;
        endcase
      end else begin
        // Resync to whatever the lamps say; a lone yellow is taken as YELLOW1
        seq_err_s = 1'b1;
        case (lamps_s)
          L_G:     next_phase_s = PH_GREEN;
          L_R:     next_phase_s = PH_RED;
          default: next_phase_s = PH_YELLOW1;
        endcase
      end
    end else begin
      // Same lamp held: flag overrun only on the edge that starts cycle LEN+1
      long_s = timed_s && (held_len_s == len_s);
    end
  end

  // Count consistency and error prioritisation
  always_comb begin
    exp_cnt_s = changed_s ? 4'd0 : held_len_s[3:0];
    if (CHK_COUNT && (next_phase_s != PH_IDLE) && (next_phase_s != PH_FAULT)) begin
      cnt_bad_s = (in_count != exp_cnt_s);
    end else begin
      cnt_bad_s = 1'b0;
    end
    if (multi_s) begin
      code_s = ERR_MULTI;
    end else if (seq_err_s) begin
      code_s = ERR_SEQ;
    end else if (short_s) begin
      code_s = ERR_SHORT;
    end else if (long_s) begin
      code_s = ERR_LONG;
    end else if (cnt_bad_s) begin
      code_s = ERR_COUNT;
    end else begin
      code_s = ERR_NONE;
    end
  end

  // State, run counter and registered status outputs
  always_ff @(posedge in_clk or posedge in_rst) begin
    if (in_rst) begin
      phase_r    <= PH_IDLE;
      rc_r       <= 8'd0;
      err_r      <= 1'b0;
      err_code_r <= 3'd0;
      cycles_r   <= 8'd0;
    end else begin
      phase_r <= next_phase_s;
      if (changed_s) begin
        rc_r <= 8'd0;
      end else if (rc_r != 8'd255) begin
        rc_r <= rc_r + 8'd1;
      end else begin
        rc_r <= rc_r;
      end
      err_r <= (code_s != ERR_NONE);
      // A newly detected error beats a simultaneous clear
      if ((code_s != ERR_NONE) && ((err_code_r == ERR_NONE) || in_clr)) begin
        err_code_r <= code_s;
      end else if (in_clr) begin
        err_code_r <= ERR_NONE;
      end else begin
        err_code_r <= err_code_r;
      end
      if (in_clr) begin
        cycles_r <= wrap_s ? 8'd1 : 8'd0;
      end else if (wrap_s) begin
        cycles_r <= cycles_r + 8'd1;
      end else begin
        cycles_r <= cycles_r;
      end
    end
  end

  assign o_phase    = phase_r;
  assign o_err      = err_r;
  assign o_err_code = err_code_r;
  assign o_cycles   = cycles_r;

endmodule

// File: tb/tb_traffic_monitor.sv
// Directed bench for traffic_monitor: table-driven clean/long-error run
// plus hand sequences for the multi-cycle corner cases.
module tb_traffic_monitor;

  logic       in_clk = 1'b0;
  logic       in_rst;
  logic       in_green;
  logic       in_yellow;
  logic       in_red;
  logic [3:0] in_count;
  logic       in_clr;

  logic [2:0] ph_a;
  logic       err_a;
  logic [2:0] code_a;
  logic [7:0] cyc_a;
  logic [2:0] ph_b;
  logic       err_b;
  logic [2:0] code_b;
  logic [7:0] cyc_b;

  traffic_monitor dut_a (
    .in_clk    (in_clk),
    .in_rst    (in_rst),
    .in_green  (in_green),
    .in_yellow (in_yellow),
    .in_red    (in_red),
    .in_count  (in_count),
    .in_clr    (in_clr),
    .o_phase   (ph_a),
    .o_err     (err_a),
    .o_err_code(code_a),
    .o_cycles  (cyc_a)
  );

  traffic_monitor #(.CHK_COUNT(1'b0)) dut_b (
    .in_clk    (in_clk),
    .in_rst    (in_rst),
    .in_green  (in_green),
    .in_yellow (in_yellow),
    .in_red    (in_red),
    .in_count  (in_count),
    .in_clr    (in_clr),
    .o_phase   (ph_b),
    .o_err     (err_b),
    .o_err_code(code_b),
    .o_cycles  (cyc_b)
  );

  always #5 in_clk = ~in_clk;

  typedef struct {
    logic       g;
    logic       y;
    logic       r;
    logic [3:0] cnt;
    logic       clr;
    logic [2:0] ph;
    logic       err;
    logic [2:0] code;
    logic [7:0] cyc;
  } vec_t;

  vec_t vecs[$];
  int   checks   = 0;
  int   failures = 0;

  function automatic void add(input logic g, input logic y, input logic r, input int cnt,
                              input logic clr, input int ph, input logic err, input int code,
                              input int cyc);
    vec_t v;
    v.g = g; v.y = y; v.r = r; v.cnt = 4'(cnt); v.clr = clr;
    v.ph = 3'(ph); v.err = err; v.code = 3'(code); v.cyc = 8'(cyc);
    vecs.push_back(v);
  endfunction

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Apply one sample, clock it in and settle just after the edge
  task automatic drive(input logic g, input logic y, input logic r, input logic [3:0] cnt,
                       input logic clr);
    in_green = g; in_yellow = y; in_red = r; in_count = cnt; in_clr = clr;
    @(posedge in_clk);
    #1;
  endtask

  // Hold one lamp n cycles with a clean count, checking phase and no error
  task automatic run_phase(input logic g, input logic y, input logic r, input int n,
                           input logic [2:0] ph, input string nm);
    for (int i = 0; i < n; i++) begin
      drive(g, y, r, 4'(i), 1'b0);
      check($sformatf("%s[%0d] phase", nm, i), 8'(ph_a), 8'(ph));
      check($sformatf("%s[%0d] err", nm, i), 8'(err_a), 8'd0);
    end
  endtask

  task automatic do_reset();
    in_rst = 1'b1;
    in_green = 1'b0; in_yellow = 1'b0; in_red = 1'b0; in_count = 4'd0; in_clr = 1'b0;
    @(posedge in_clk);
    #1;
    in_rst = 1'b0;
  endtask

  initial begin
    in_rst = 1'b1;
    in_green = 1'b0; in_yellow = 1'b0; in_red = 1'b0; in_count = 4'd0; in_clr = 1'b0;
    repeat (2) @(posedge in_clk);
    #1;
    check("reset phase", 8'(ph_a), 8'd0);
    check("reset err", 8'(err_a), 8'd0);
    check("reset code", 8'(code_a), 8'd0);
    check("reset cycles", cyc_a, 8'd0);
    in_rst = 1'b0;

    // Clean full cycle, then green overrun (12th sample flags once)
    add(0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 11; i++) add(1, 0, 0, i, 0, 1, 0, 0, 0);
    for (int i = 0; i < 6; i++)  add(0, 1, 0, i, 0, 2, 0, 0, 0);
    for (int i = 0; i < 16; i++) add(0, 0, 1, i, 0, 3, 0, 0, 0);
    for (int i = 0; i < 6; i++)  add(0, 1, 0, i, 0, 4, 0, 0, 0);
    add(1, 0, 0, 0, 0, 1, 0, 0, 1);
    for (int i = 1; i < 11; i++) add(1, 0, 0, i, 0, 1, 0, 0, 1);
    add(1, 0, 0, 11, 0, 1, 1, 4, 1);
    add(1, 0, 0, 12, 0, 1, 0, 4, 1);
    add(1, 0, 0, 13, 0, 1, 0, 4, 1);

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].g, vecs[i].y, vecs[i].r, vecs[i].cnt, vecs[i].clr);
      check($sformatf("vec%0d phase", i), 8'(ph_a), 8'(vecs[i].ph));
      check($sformatf("vec%0d err", i), 8'(err_a), 8'(vecs[i].err));
      check($sformatf("vec%0d code", i), 8'(code_a), 8'(vecs[i].code));
      check($sformatf("vec%0d cycles", i), cyc_a, vecs[i].cyc);
    end

    // Green then red, skipping yellow
    do_reset();
    drive(1'b0, 1'b0, 1'b0, 4'd0, 1'b0);
    run_phase(1'b1, 1'b0, 1'b0, 11, 3'd1, "skip_g");
    drive(1'b0, 1'b0, 1'b1, 4'd0, 1'b0);
    check("skip phase", 8'(ph_a), 8'd3);
    check("skip err", 8'(err_a), 8'd1);
    check("skip code", 8'(code_a), 8'd2);

    // Yellow1 cut short
    do_reset();
    drive(1'b0, 1'b0, 1'b0, 4'd0, 1'b0);
    run_phase(1'b1, 1'b0, 1'b0, 11, 3'd1, "short_g");
    run_phase(1'b0, 1'b1, 1'b0, 4, 3'd2, "short_y");
    drive(1'b0, 1'b0, 1'b1, 4'd0, 1'b0);
    check("short phase", 8'(ph_a), 8'd3);
    check("short err", 8'(err_a), 8'd1);
    check("short code", 8'(code_a), 8'd3);

    // Two lamps together, FAULT only released by dark
    do_reset();
    drive(1'b0, 1'b0, 1'b0, 4'd0, 1'b0);
    drive(1'b1, 1'b0, 1'b1, 4'd0, 1'b0);
    check("multi phase", 8'(ph_a), 8'd7);
    check("multi err", 8'(err_a), 8'd1);
    check("multi code", 8'(code_a), 8'd1);
    drive(1'b1, 1'b0, 1'b0, 4'd0, 1'b0);
    check("fault hold phase", 8'(ph_a), 8'd7);
    check("fault hold err", 8'(err_a), 8'd0);
    drive(1'b0, 1'b0, 1'b0, 4'd0, 1'b0);
    check("fault exit phase", 8'(ph_a), 8'd0);
    check("fault exit code", 8'(code_a), 8'd1);

    // Count mismatch on 3rd green cycle; the CHK_COUNT=0 instance ignores it
    do_reset();
    drive(1'b0, 1'b0, 1'b0, 4'd0, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 4'd0, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 4'd1, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 4'd5, 1'b0);
    check("cnt err", 8'(err_a), 8'd1);
    check("cnt code", 8'(code_a), 8'd5);
    check("nocnt err", 8'(err_b), 8'd0);
    check("nocnt code", 8'(code_b), 8'd0);
    check("nocnt phase", 8'(ph_b), 8'd1);

    // Reach RED in the second light cycle with a sticky code, then async reset
    drive(1'b0, 1'b0, 1'b0, 4'd0, 1'b0);
    check("pre idle phase", 8'(ph_a), 8'd0);
    check("pre idle code", 8'(code_a), 8'd5);
    run_phase(1'b1, 1'b0, 1'b0, 11, 3'd1, "pre_g1");
    run_phase(1'b0, 1'b1, 1'b0, 6, 3'd2, "pre_y1");
    run_phase(1'b0, 1'b0, 1'b1, 16, 3'd3, "pre_r1");
    run_phase(1'b0, 1'b1, 1'b0, 6, 3'd4, "pre_y2");
    run_phase(1'b1, 1'b0, 1'b0, 11, 3'd1, "pre_g2");
    run_phase(1'b0, 1'b1, 1'b0, 6, 3'd2, "pre_y3");
    run_phase(1'b0, 1'b0, 1'b1, 5, 3'd3, "pre_r2");
    check("pre rst cycles", cyc_a, 8'd1);
    check("pre rst code", 8'(code_a), 8'd5);
    #2;
    in_rst = 1'b1;
    #1;
    check("async rst phase", 8'(ph_a), 8'd0);
    check("async rst err", 8'(err_a), 8'd0);
    check("async rst code", 8'(code_a), 8'd0);
    check("async rst cycles", cyc_a, 8'd0);
    @(posedge in_clk);
    #1;
    in_rst = 1'b0;

    // Clean sequence after reset
    drive(1'b0, 1'b0, 1'b0, 4'd0, 1'b0);
    run_phase(1'b1, 1'b0, 1'b0, 11, 3'd1, "post_g");
    run_phase(1'b0, 1'b1, 1'b0, 6, 3'd2, "post_y1");
    run_phase(1'b0, 1'b0, 1'b1, 16, 3'd3, "post_r");
    run_phase(1'b0, 1'b1, 1'b0, 6, 3'd4, "post_y2");
    drive(1'b1, 1'b0, 1'b0, 4'd0, 1'b0);
    check("post wrap phase", 8'(ph_a), 8'd1);
    check("post wrap err", 8'(err_a), 8'd0);
    check("post wrap code", 8'(code_a), 8'd0);
    check("post wrap cycles", cyc_a, 8'd1);

    // Sticky count error, then clear on the same edge as a long error
    for (int i = 1; i < 11; i++) begin
      drive(1'b1, 1'b0, 1'b0, (i == 3) ? 4'd9 : 4'(i), 1'b0);
      check($sformatf("clr_g[%0d] err", i), 8'(err_a), (i == 3) ? 8'd1 : 8'd0);
    end
    check("clr pre code", 8'(code_a), 8'd5);
    drive(1'b1, 1'b0, 1'b0, 4'd11, 1'b1);
    check("clr+long err", 8'(err_a), 8'd1);
    check("clr+long code", 8'(code_a), 8'd4);
    check("clr+long cycles", cyc_a, 8'd0);
    drive(1'b1, 1'b0, 1'b0, 4'd12, 1'b1);
    check("clr only err", 8'(err_a), 8'd0);
    check("clr only code", 8'(code_a), 8'd0);
    check("clr only phase", 8'(ph_a), 8'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
